hc_multiword_add_seq: RTL and testbench
=======================================

// Module: hc_multiword_add_seq
// PURPOSE
//  Sequencer that reuses one 16-bit HanCarlson prefix adder (A,B,Cin -> Sum,Cout) to add or
//  subtract WORDS*16-bit operands. One 16-bit slice is processed per cycle, LSW first, and the
//  carry is registered between slices. Sits between the operand source and result consumer,
//  with valid/ready handshakes on both sides.
// PARAMETERS
//  WORDS  4  number of 16-bit slices; legal 1..16; operand width W = 16*WORDS
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  operand request valid
//  in_ready   out  1  block can accept an operand request
//  in_a       in   W  operand A
//  in_b       in   W  operand B
//  in_sub     in   1  1 = A-B (two's complement), 0 = A+B+in_cin
//  in_cin     in   1  carry-in for add; ignored when in_sub=1
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  out_sum    out  W  result
//  out_cout   out  1  final carry-out (for subtract: 1 = no borrow)
//  out_ovf    out  1  signed two's-complement overflow
//  busy       out  1  high in RUN or DONE
// BEHAVIOUR
//  States: IDLE, RUN, DONE. Reset -> IDLE, cnt=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
//  in_ready = (state==IDLE) & ~rst. busy = (state!=IDLE).
//  IDLE: on in_valid&in_ready:
//   - latch a_reg=in_a and b_reg = in_sub ? ~in_b : in_b
//   - carry_reg = in_sub ? 1 : in_cin; cnt=0; go RUN
//  RUN: adder A=a_reg[16*cnt+:16], B=b_reg[16*cnt+:16], Cin=carry_reg.
//   - out_sum[16*cnt+:16] <= Sum; carry_reg <= Cout; cnt <= cnt+1
//   - when cnt==WORDS-1, also: out_cout <= Cout;
//     out_ovf <= (a_reg[W-1]==b_reg[W-1]) & (Sum[15]!=a_reg[W-1]); go DONE
//  DONE: out_valid=1; out_sum/out_cout/out_ovf held stable until out_valid&out_ready.
//   - On that handshake: out_valid drops next cycle; go IDLE.
//  Latency: request accepted at edge k -> out_valid high after edge k+WORDS.
//   - Min issue period WORDS+2 cycles with out_ready tied high.
//  out_sum is updated slice by slice in RUN and is meaningful only while out_valid=1.
//  Inputs are sampled only at the accept edge; later changes to in_a/in_b/in_sub/in_cin have
//   no effect on an operation in flight.
//  in_valid while busy: not accepted (in_ready=0); the source holds its request.
//  WORDS=1: RUN lasts exactly one cycle; cnt never exceeds 0.
//  cnt width = max(1, clog2(WORDS)); never wraps because the block leaves RUN at WORDS-1.
//  rst in any state (incl. mid-RUN or DONE awaiting out_ready): next cycle IDLE with all
//   outputs at reset values; the in-flight operation is dropped and produces no result.
//  Arithmetic is modulo 2^W; the carry chain across slices equals a single W-bit add.
// TESTING (WORDS=4 unless noted)
//  1 add A=64'h0000_0000_0000_FFFF, B=1, cin=0 -> sum 64'h0000_0000_0001_0000, cout 0, ovf 0,
//    out_valid exactly 4 cycles after accept
//  2 add A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> sum 0, cout 1, ovf 0; then
//    A=B=64'h7FFF_FFFF_FFFF_FFFF, cin=0 -> sum 64'hFFFF_FFFF_FFFF_FFFE, ovf 1
//  3 sub A=0, B=1 -> sum 64'hFFFF_FFFF_FFFF_FFFF, cout 0, ovf 0; then
//    A=64'h8000_0000_0000_0000, B=1 -> sum 64'h7FFF_FFFF_FFFF_FFFF, cout 1, ovf 1
//  4 hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, outputs stable, in_ready 0;
//    with in_valid also high, no second accept until after the result handshake
//  5 assert rst for 1 cycle at cnt=2 in RUN -> next cycle IDLE, out_valid 0, in_ready 1,
//    no result emitted; a fresh request then completes correctly
//  6 WORDS=1 and WORDS=4, 1000 random ops (random sub/cin, random in_valid/out_ready)
//    -> every result matches a W-bit reference model; results in order, none lost or duplicated

Source files
------------

// File: rtl/hc_multiword_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : hc_prefix16
//  Purpose  : 16-bit Han-Carlson parallel-prefix adder with carry-in.
//             Odd bit positions form a Kogge-Stone tree. Even positions are
//             resolved in one extra level from their odd neighbour.
//  Ports    : a, b   - 16-bit addends
//             cin    - carry into bit 0
//             sum    - 16-bit sum
//             cout   - carry out of bit 15
//  Revision : 1.0  initial release
// ============================================================================
module hc_prefix16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] pk;      // raw half-sum, needed again for the sum bits
  logic [15:0] g;       // group generate, refined level by level
  logic [15:0] p;       // group propagate, refined level by level
  logic [15:0] ng;
  logic [15:0] np;
  logic [15:0] carry;   // carry[i] = carry out of bit i (cin included)

  assign pk = a ^ b;

  always_comb begin
    g     = a & b;
    p     = pk;
    ng    = '0;
    np    = '0;
    carry = '0;

    // Fold cin into bit 0 so every prefix group already accounts for it.
    g[0] = g[0] | (p[0] & cin);

    // Level 1: each odd bit absorbs its even neighbour.
    ng = g;
    np = p;
    for (int i = 1; i < 16; i += 2) begin
      ng[i] = g[i] | (p[i] & g[i-1]);
      np[i] = p[i] & p[i-1];
    end
    g = ng;
    p = np;

    // Levels 2..4: Kogge-Stone over odd bits only, span 2, 4, 8.
    for (int d = 2; d < 16; d = d * 2) begin
      ng = g;
      np = p;
      for (int i = d + 1; i < 16; i += 2) begin
        ng[i] = g[i] | (p[i] & g[i-d]);
        np[i] = p[i] & p[i-d];
      end
      g = ng;
      p = np;
    end

    // Final level: even bits take the finished carry of the odd bit below.
    // Even-bit p is still the raw propagate here.
    for (int i = 2; i < 16; i += 2) begin
      g[i] = g[i] | (p[i] & g[i-1]);
    end

    carry = g;
  end

  assign sum  = pk ^ {carry[14:0], cin};
  assign cout = carry[15];

endmodule

// ============================================================================
//  Module   : hc_multiword_add_seq
//  Purpose  : Multi-word add/subtract sequencer. One 16-bit Han-Carlson
//             adder is reused for WORDS slices, LSW first, with the carry
//             registered between slices. Valid/ready on both sides.
//  Params   : WORDS     - number of 16-bit slices (1..16), W = 16*WORDS
//  Ports    : clk       - clock, rising edge
//             rst       - synchronous active-high reset
//             in_valid  - operand request valid
//             in_ready  - block can accept a request (IDLE, not in reset)
//             in_a      - operand A (W bits)
//             in_b      - operand B (W bits)
//             in_sub    - 1: A-B, 0: A+B+in_cin
//             in_cin    - carry-in for add, ignored for subtract
//             out_valid - result valid
//             out_ready - consumer accepts result
//             out_sum   - result (W bits)
//             out_cout  - final carry-out (subtract: 1 = no borrow)
//             out_ovf   - signed two's-complement overflow
//             busy      - operation in RUN or waiting in DONE
//  Revision : 1.0  initial release
// ============================================================================
module hc_multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*WORDS-1:0]  in_a,
  input  logic [16*WORDS-1:0]  in_b,
  input  logic                 in_sub,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*WORDS-1:0]  out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WORDS-1:0][15:0] a_reg;
  logic [WORDS-1:0][15:0] b_reg;      // already inverted for subtract
  logic [WORDS-1:0][15:0] sum_reg;
  logic                   carry_reg;
  logic [CW-1:0]          cnt;
  logic                   cout_reg;
  logic                   ovf_reg;

  logic [15:0]            slice_sum;
  logic                   slice_cout;
  logic                   accept;
  logic                   last_slice;
  logic                   slice_ovf;

  assign in_ready   = (state == IDLE) & ~rst;
  assign accept     = in_valid & in_ready;
  assign last_slice = (cnt == LAST);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_sum    = sum_reg;
  assign out_cout   = cout_reg;
  assign out_ovf    = ovf_reg;

  // Overflow looks at the effective operands (B already inverted for
  // subtract), so the same rule serves both add and subtract.
  assign slice_ovf = (a_reg[WORDS-1][15] == b_reg[WORDS-1][15]) &
                     (slice_sum[15] != a_reg[WORDS-1][15]);

  hc_prefix16 u_adder (
    .a    (a_reg[cnt]),
    .b    (b_reg[cnt]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (accept) begin
        a_reg     <= in_a;
        // Subtract is A + ~B + 1: invert B here, inject the +1 as carry-in.
        b_reg     <= in_sub ? ~in_b : in_b;
        carry_reg <= in_sub | in_cin;
        cnt       <= '0;
      end

      if (state == RUN) begin
        sum_reg[cnt] <= slice_sum;
        carry_reg    <= slice_cout;
        if (last_slice) begin
          cout_reg <= slice_cout;
          ovf_reg  <= slice_ovf;
        end else begin
          // Held at the last index rather than wrapping.
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hc_multiword_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hc_multiword_add_seq
//  Purpose  : Self-checking bench for hc_multiword_add_seq. Two instances:
//             WORDS=4 (index 0) and WORDS=1 (index 1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_hc_multiword_add_seq;

  localparam int NOPS    = 1000;
  localparam int TMO     = 50;
  localparam int CYC_MAX = 40000;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ov;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [63:0] in_a      [2];
  logic [63:0] in_b      [2];
  logic        in_sub    [2];
  logic        in_cin    [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        out_cout  [2];
  logic        out_ovf   [2];
  logic        busy      [2];
  logic [63:0] sum4;
  logic [15:0] sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hc_multiword_add_seq #(.WORDS(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_a      (in_a[0]),
    .in_b      (in_b[0]),
    .in_sub    (in_sub[0]),
    .in_cin    (in_cin[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_sum   (sum4),
    .out_cout  (out_cout[0]),
    .out_ovf   (out_ovf[0]),
    .busy      (busy[0])
  );

  hc_multiword_add_seq #(.WORDS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_a      (in_a[1][15:0]),
    .in_b      (in_b[1][15:0]),
    .in_sub    (in_sub[1]),
    .in_cin    (in_cin[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_sum   (sum1),
    .out_cout  (out_cout[1]),
    .out_ovf   (out_ovf[1]),
    .busy      (busy[1])
  );

  function automatic logic [63:0] get_sum(input int idx);
    return (idx == 0) ? sum4 : {48'd0, sum1};
  endfunction

  function automatic res_t get_res(input int idx);
    res_t r;
    r.s  = get_sum(idx);
    r.co = out_cout[idx];
    r.ov = out_ovf[idx];
    return r;
  endfunction

  // Reference: plain W-bit integer arithmetic.
  function automatic res_t model(input int idx, input logic [63:0] a,
                                 input logic [63:0] b, input logic sub,
                                 input logic cin);
    int          w;
    logic [64:0] mask;
    logic [64:0] aa;
    logic [64:0] bb;
    logic [64:0] full;
    logic        sa;
    logic        sb;
    res_t        r;
    w    = (idx == 0) ? 64 : 16;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = {1'b0, b} & mask;
    sa   = aa[w-1];
    sb   = bb[w-1];
    if (sub) begin
      full = aa - bb;
      r.s  = full[63:0] & mask[63:0];
      r.co = (aa >= bb);
      r.ov = (sa != sb) && (r.s[w-1] != sa);
    end else begin
      full = aa + bb + {64'd0, cin};
      r.s  = full[63:0] & mask[63:0];
      r.co = full[w];
      r.ov = (sa == sb) && (r.s[w-1] != sa);
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = {64{1'b1}};
      2:       v = {4{16'h8000}};
      3:       v = {4{16'h7FFF}};
      4:       v = {4{16'h0001}};
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  // Issue one request to an idle instance, wait for the result, take it.
  // lat = edges from the accept edge to out_valid (TMO on timeout).
  task automatic run_op(input int idx, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input logic cin,
                        output res_t r, output int lat);
    in_a[idx]      = a;
    in_b[idx]      = b;
    in_sub[idx]    = sub;
    in_cin[idx]    = cin;
    in_valid[idx]  = 1'b1;
    out_ready[idx] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    lat = 0;
    while (!out_valid[idx] && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    r = get_res(idx);
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: in_ready=%b out_valid=%b, required 0 0",
                 i, in_ready[i], out_valid[i]);
      end
    end
    in_valid[0] = 1'b0;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || busy[i] !== 1'b0 || out_valid[i] !== 1'b0 ||
          get_sum(i) !== 64'd0 || out_cout[i] !== 1'b0 || out_ovf[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: rdy=%b busy=%b vld=%b sum=%h co=%b ov=%b, required 1 0 0 0 0 0",
                 i, in_ready[i], busy[i], out_valid[i], get_sum(i), out_cout[i], out_ovf[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_add_basic();
    res_t r;
    int   lat;
    run_op(0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, r, lat);
    checks++;
    if (r.s !== 64'h0000_0000_0001_0000 || r.co !== 1'b0 || r.ov !== 1'b0) begin
      errors++;
      $display("FAIL add_slice_carry: got %h co=%b ov=%b, required 0000000000010000 co=0 ov=0",
               r.s, r.co, r.ov);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL latency: got %0d edges, required 4", lat);
    end
  endtask

  task automatic test_add_carry();
    res_t r;
    int   lat;
    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, r, lat);
    checks++;
    if (r.s !== 64'd0 || r.co !== 1'b1 || r.ov !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap_cin: got %h co=%b ov=%b, required 0 co=1 ov=0", r.s, r.co, r.ov);
    end
    run_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, r, lat);
    checks++;
    if (r.s !== 64'hFFFF_FFFF_FFFF_FFFE || r.co !== 1'b0 || r.ov !== 1'b1) begin
      errors++;
      $display("FAIL add_overflow: got %h co=%b ov=%b, required fffffffffffffffe co=0 ov=1",
               r.s, r.co, r.ov);
    end
  endtask

  task automatic test_sub();
    res_t r;
    int   lat;
    // in_cin=1 must be ignored for subtract
    run_op(0, 64'd0, 64'd1, 1'b1, 1'b1, r, lat);
    checks++;
    if (r.s !== 64'hFFFF_FFFF_FFFF_FFFF || r.co !== 1'b0 || r.ov !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: got %h co=%b ov=%b, required ffffffffffffffff co=0 ov=0",
               r.s, r.co, r.ov);
    end
    run_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, r, lat);
    checks++;
    if (r.s !== 64'h7FFF_FFFF_FFFF_FFFF || r.co !== 1'b1 || r.ov !== 1'b1) begin
      errors++;
      $display("FAIL sub_overflow: got %h co=%b ov=%b, required 7fffffffffffffff co=1 ov=1",
               r.s, r.co, r.ov);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a1, b1, a2, b2;
    logic        s1, c1, s2, c2;
    res_t        e1, e2, held, cur;
    int          n;
    a1 = rand_op(); b1 = rand_op(); s1 = 1'($urandom()); c1 = 1'($urandom());
    a2 = rand_op(); b2 = rand_op(); s2 = 1'($urandom()); c2 = 1'($urandom());
    e1 = model(0, a1, b1, s1, c1);
    e2 = model(0, a2, b2, s2, c2);

    in_a[0] = a1; in_b[0] = b1; in_sub[0] = s1; in_cin[0] = c1;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Second request presented immediately and held throughout.
    in_a[0] = a2; in_b[0] = b2; in_sub[0] = s2; in_cin[0] = c2;
    n = 0;
    while (!out_valid[0] && n < TMO) begin
      @(negedge clk);
      n++;
    end
    cur = get_res(0);
    checks++;
    if (out_valid[0] !== 1'b1 || cur !== e1) begin
      errors++;
      $display("FAIL bp_first_result: vld=%b got %h/%b/%b, required %h/%b/%b",
               out_valid[0], cur.s, cur.co, cur.ov, e1.s, e1.co, e1.ov);
    end
    held = cur;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cur = get_res(0);
      checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || cur !== held) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: vld=%b rdy=%b got %h/%b/%b, required 1 0 %h/%b/%b",
                 k, out_valid[0], in_ready[0], cur.s, cur.co, cur.ov, held.s, held.co, held.ov);
      end
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b, required 0 1", out_valid[0], in_ready[0]);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept: busy=%b rdy=%b, required 1 0", busy[0], in_ready[0]);
    end
    n = 0;
    while (!out_valid[0] && n < TMO) begin
      @(negedge clk);
      n++;
    end
    cur = get_res(0);
    checks++;
    if (out_valid[0] !== 1'b1 || cur !== e2 || n !== 4) begin
      errors++;
      $display("FAIL bp_second_result: vld=%b lat=%0d got %h/%b/%b, required 4 %h/%b/%b",
               out_valid[0], n, cur.s, cur.co, cur.ov, e2.s, e2.co, e2.ov);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
  endtask

  task automatic test_reset_midrun();
    res_t r, e;
    int   lat;
    logic seen;
    in_a[0] = 64'h1234_5678_9ABC_DEF0; in_b[0] = 64'h0FED_CBA9_8765_4321;
    in_sub[0] = 1'b0; in_cin[0] = 1'b0;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);            // cnt = 0
    in_valid[0] = 1'b0;
    @(negedge clk);            // cnt = 1
    @(negedge clk);            // cnt = 2
    checks++;
    if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrun_busy: busy=%b vld=%b, required 1 0", busy[0], out_valid[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0 ||
        get_sum(0) !== 64'd0 || out_cout[0] !== 1'b0 || out_ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: vld=%b rdy=%b busy=%b sum=%h co=%b ov=%b, required 0 1 0 0 0 0",
               out_valid[0], in_ready[0], busy[0], get_sum(0), out_cout[0], out_ovf[0]);
    end
    out_ready[0] = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) seen = 1'b1;
    end
    out_ready[0] = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrun_dropped: out_valid seen=%b, required 0", seen);
    end
    e = model(0, 64'hFFFF_0000_FFFF_0001, 64'h0000_FFFF_0000_FFFF, 1'b1, 1'b0);
    run_op(0, 64'hFFFF_0000_FFFF_0001, 64'h0000_FFFF_0000_FFFF, 1'b1, 1'b0, r, lat);
    checks++;
    if (r !== e || lat !== 4) begin
      errors++;
      $display("FAIL midrun_fresh: lat=%0d got %h/%b/%b, required 4 %h/%b/%b",
               lat, r.s, r.co, r.ov, e.s, e.co, e.ov);
    end
  endtask

  task automatic test_random(input int idx);
    res_t q[$];
    res_t e, cur, held;
    int   acc, got, cyc;
    logic stall_prev;
    acc = 0; got = 0; cyc = 0;
    stall_prev = 1'b0;
    held = '0;
    while ((acc < NOPS || q.size() != 0) && cyc < CYC_MAX) begin
      if (acc < NOPS) begin
        in_valid[idx] = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid[idx] = 1'b0;
      end
      in_a[idx]      = rand_op();
      in_b[idx]      = rand_op();
      in_sub[idx]    = 1'($urandom());
      in_cin[idx]    = 1'($urandom());
      out_ready[idx] = ($urandom_range(0, 2) != 0);
      #1;
      cur = get_res(idx);
      if (stall_prev) begin
        checks++;
        if (out_valid[idx] !== 1'b1 || cur !== held) begin
          errors++;
          $display("FAIL rnd%0d_stall_hold: vld=%b got %h/%b/%b, required 1 %h/%b/%b",
                   idx, out_valid[idx], cur.s, cur.co, cur.ov, held.s, held.co, held.ov);
        end
      end
      if (in_valid[idx] && in_ready[idx]) begin
        q.push_back(model(idx, in_a[idx], in_b[idx], in_sub[idx], in_cin[idx]));
        acc++;
      end
      if (out_valid[idx] && out_ready[idx]) begin
        got++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd%0d_extra_result: got %h with no outstanding request", idx, cur.s);
        end else begin
          e = q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL rnd%0d_result #%0d: got %h/%b/%b, required %h/%b/%b",
                     idx, got, cur.s, cur.co, cur.ov, e.s, e.co, e.ov);
          end
        end
      end
      stall_prev = out_valid[idx] && !out_ready[idx];
      held = cur;
      @(negedge clk);
      cyc++;
    end
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b0;
    checks++;
    if (acc != NOPS || got != NOPS || q.size() != 0) begin
      errors++;
      $display("FAIL rnd%0d_count: accepted %0d results %0d pending %0d after %0d cycles, required %0d %0d 0",
               idx, acc, got, q.size(), cyc, NOPS, NOPS);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_a[i]      = 64'd0;
      in_b[i]      = 64'd0;
      in_sub[i]    = 1'b0;
      in_cin[i]    = 1'b0;
      out_ready[i] = 1'b0;
    end
    rst = 1'b1;

    test_reset();
    test_add_basic();
    test_add_carry();
    test_sub();
    test_backpressure();
    test_reset_midrun();
    test_random(0);
    test_random(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
